uart_tx_fifo: RTL and testbench

Byte-wide UART transmitter with a small input FIFO, driving the board's serial-out pin at 115200 baud from the 100 MHz system clock. It is the transmit counterpart of the UART receive/display path. Logic upstream (receive path echo, debug producers) pushes bytes through a valid/ready handshake. The block serialises each byte as 8N1 (optionally 8E1) on `txd`, with frames sent back-to-back while data is queued.

---
 rtl/uart_tx_fifo_if.sv | 20 ++
 rtl/uart_tx_fifo.sv | 171 +++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// Byte-stream handshake between a producer and uart_tx_fifo.
// Signals: tx_data (byte), tx_valid (offer), tx_ready (FIFO not full).
// A byte transfers on a rising edge where tx_valid && tx_ready.
interface uart_tx_fifo_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter (8N1, or 8E1 when UART_TX_PARITY_EN is defined) with input FIFO.
// Ports: clk, rst (sync, active high), tx (slave handshake: tx_data/tx_valid/tx_ready),
//        hold (block new frames), txd (serial out, idle 1), busy, fifo_count.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_AW      = 2
) (
    input  logic               clk,
    input  logic               rst,
    uart_tx_fifo_if.slave      tx,
    input  logic               hold,
    output logic               txd,
    output logic               busy,
    output logic [FIFO_AW:0]   fifo_count
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0]    CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_AW:0] FULL     = (FIFO_AW + 1)'(DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd4;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif

    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               ready_q;

    logic [2:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2:0]         idx_q, idx_d;
    logic [7:0]         sh_q, sh_d;
    logic               txd_q, txd_d;
    logic               busy_q;

    logic push, pop, bit_end, can_load;

    assign push     = tx.tx_valid & ready_q;
    assign bit_end  = (cnt_q == CNT_LAST);
    // Registered count: a byte pushed this edge is only visible next edge (no bypass).
    assign can_load = (count_q != '0) & ~hold;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        txd_d   = txd_q;
        pop     = 1'b0;

        // Free-running bit timer while a frame is on the line.
        if (state_q != S_IDLE)
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                txd_d = 1'b1;
                if (can_load) begin
                    pop     = 1'b1;
                    sh_d    = mem_q[rd_ptr_q];
                    txd_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    idx_d   = 3'd0;
                    txd_d   = sh_q[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        txd_d   = ^sh_q;
`else
                        state_d = S_STOP;
                        txd_d   = 1'b1;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                        txd_d = sh_q[idx_q + 3'd1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    txd_d   = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    // Reload straight into START so queued frames abut.
                    if (can_load) begin
                        pop     = 1'b1;
                        sh_d    = mem_q[rd_ptr_q];
                        txd_d   = 1'b0;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                txd_d   = 1'b1;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            sh_q     <= '0;
            txd_q    <= 1'b1;
            busy_q   <= 1'b0;
            count_q  <= '0;
            ready_q  <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            sh_q     <= sh_d;
            txd_q    <= txd_d;
            busy_q   <= (state_d != S_IDLE);
            count_q  <= count_d;
            ready_q  <= (count_d != FULL);
            if (push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= tx.tx_data;
    end

    assign tx.tx_ready = ready_q;
    assign txd         = txd_q;
    assign busy        = busy_q;
    assign fifo_count  = count_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus queues expected bytes,
// a serial monitor decodes txd frames and compares against the queue.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
    localparam int CPB = 8;
    localparam int AW  = 2;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          hold = 1'b0;
    logic          txd, busy;
    logic [AW:0]   fifo_count;

    uart_tx_fifo_if ifc ();

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .tx         (ifc.slave),
        .hold       (hold),
        .txd        (txd),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] exp_q [$];
    int st_q [$];
    int frames_done = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Serial monitor
    logic        m_act = 1'b0;
    int          m_bit, m_cnt, m_start;
    logic        m_lvl, m_glitch, m_busy_bad;
    logic [10:0] m_frm;

    task automatic check_frame();
        logic [7:0] d, e;
        d = m_frm[8:1];
        chk("start_bit", m_frm[0], 1'b0);
        chk("stop_bit", m_frm[NBITS-1], 1'b1);
        chk("bit_stable", m_glitch, 1'b0);
        chk("busy_in_frame", m_busy_bad, 1'b0);
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_frame: got byte %02h, none expected", d);
        end else begin
            e = exp_q.pop_front();
            chk("frame_data", d, e);
`ifdef UART_TX_PARITY_EN
            chk("parity_bit", m_frm[9], ^e);
`endif
        end
        st_q.push_back(m_start);
        frames_done++;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            m_act = 1'b0;
        end else if (!m_act) begin
            if (txd === 1'b0) begin
                m_act      = 1'b1;
                m_bit      = 0;
                m_cnt      = 1;
                m_lvl      = 1'b0;
                m_glitch   = 1'b0;
                m_busy_bad = (busy !== 1'b1);
                m_start    = cyc;
            end
        end else begin
            if (busy !== 1'b1) m_busy_bad = 1'b1;
            if (m_cnt == 0) begin
                m_lvl = txd;
                m_cnt = 1;
            end else begin
                if (txd !== m_lvl) m_glitch = 1'b1;
                m_cnt++;
            end
        end
        if (m_act && m_cnt == CPB) begin
            m_frm[m_bit] = m_lvl;
            m_bit++;
            m_cnt = 0;
            if (m_bit == NBITS) begin
                m_act = 1'b0;
                check_frame();
            end
        end
    end

    task automatic push(input logic [7:0] d);
        int t;
        t = 0;
        ifc.tx_data  = d;
        ifc.tx_valid = 1'b1;
        while (ifc.tx_ready !== 1'b1 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("push_timeout", (t >= 2000), 1'b0);
        exp_q.push_back(d);
        @(negedge clk);
        ifc.tx_valid = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int lim);
        int t;
        t = 0;
        while (frames_done < n && t < lim) begin
            @(negedge clk);
            t++;
        end
        chk("frame_timeout", (frames_done >= n), 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, t;
        ifc.tx_data  = 8'h00;
        ifc.tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_txd", txd, 1'b1);
        chk("rst_ready", ifc.tx_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_count", fifo_count, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single byte 0x55
        push(8'h55);
        chk("lat_pre", txd, 1'b1);
        @(negedge clk);
        chk("lat_start", txd, 1'b0);
        chk("busy_start", busy, 1'b1);
        wait_frames(1, FRAME + 50);
        @(negedge clk);
        chk("busy_end", busy, 1'b0);
        chk("txd_idle", txd, 1'b1);

        // Fill and back-pressure with 0x01..0x06
        st_q.delete();
        base = frames_done;
        ifc.tx_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ifc.tx_data = 8'(i + 1);
            if (i == 5) begin
                chk("ready_full", ifc.tx_ready, 1'b0);
                chk("count_full", fifo_count, 4);
            end
            t = 0;
            while (ifc.tx_ready !== 1'b1 && t < 2000) begin
                @(negedge clk);
                t++;
            end
            chk("fill_timeout", (t >= 2000), 1'b0);
            exp_q.push_back(8'(i + 1));
            @(negedge clk);
        end
        ifc.tx_valid = 1'b0;
        wait_frames(base + 6, 6 * FRAME + 200);
        chk("b2b_frames", st_q.size(), 6);
        for (int i = 1; i < st_q.size(); i++)
            chk("b2b_gap", st_q[i] - st_q[i-1], FRAME);
        @(negedge clk);
        chk("fill_busy_end", busy, 1'b0);
        chk("fill_count_end", fifo_count, 0);

        // hold while idle
        base = frames_done;
        hold = 1'b1;
        push(8'hA3);
        repeat (20) @(negedge clk);
        chk("hold_txd", txd, 1'b1);
        chk("hold_count", fifo_count, 1);
        chk("hold_busy", busy, 1'b0);
        hold = 1'b0;
        @(negedge clk);
        chk("hold_release", txd, 1'b0);
        wait_frames(base + 1, FRAME + 50);

        // hold raised mid-frame
        base = frames_done;
        push(8'h0F);
        push(8'hF0);
        repeat (20) @(negedge clk);
        hold = 1'b1;
        wait_frames(base + 1, FRAME + 50);
        repeat (40) @(negedge clk);
        chk("midhold_txd", txd, 1'b1);
        chk("midhold_count", fifo_count, 1);
        chk("midhold_busy", busy, 1'b0);
        chk("midhold_frames", frames_done, base + 1);
        hold = 1'b0;
        wait_frames(base + 2, FRAME + 50);

        // Reset during data bit 3
        base = frames_done;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        repeat (34) @(negedge clk);
        chk("pre_rst_busy", busy, 1'b1);
        chk("pre_rst_count", fifo_count, 2);
        rst = 1'b1;
        @(negedge clk);
        exp_q.delete();
        chk("midrst_txd", txd, 1'b1);
        chk("midrst_count", fifo_count, 0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_ready", ifc.tx_ready, 1'b1);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (200) @(negedge clk);
        chk("post_rst_frames", frames_done, base);
        chk("post_rst_txd", txd, 1'b1);

`ifdef UART_TX_PARITY_EN
        base = frames_done;
        push(8'h07);
        wait_frames(base + 1, FRAME + 50);
        push(8'h03);
        wait_frames(base + 2, FRAME + 50);
`endif

        repeat (5) @(negedge clk);
        chk("exp_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
